// File: rtl/spi_slave.sv
// SPI slave, mode 0 style with LSB-first framing, oversampled on clk through
// synchronizer chains; one transmit buffer and back-to-back frames under one CS.
//
// state  | meaning
// IDLE   | CS high (synchronized); MISO released, waiting for CS fall
// ACTIVE | selected; shifting on synchronized SCLK falls, MISO driven
module spi_slave #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  SCLK,
   input  logic                  CS,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic                  MISO_oe,
   input  logic [DATA_WIDTH-1:0] slaveDataToSend,
   input  logic                  txLoad,
   output logic                  txReady,
   output logic [DATA_WIDTH-1:0] slaveDataReceived,
   output logic                  rxValid,
   output logic                  busy,
   output logic                  frameError,
   output logic                  txUnderrun
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                    sclk_prev_q, cs_prev_q;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
   logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    tx_ready_q, tx_ready_d;
   logic                    rx_valid_q, rx_valid_d;
   logic                    frame_err_q, frame_err_d;
   logic                    underrun_q, underrun_d;
   logic                    first_q, first_d;

   logic                    sclk_s, cs_s, mosi_s;
   logic                    sclk_fall, cs_fall, cs_rise, reload;
   logic [DATA_WIDTH-1:0]   shift_in;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_fall = sclk_prev_q & ~sclk_s;
   assign cs_fall   = cs_prev_q & ~cs_s;
   assign cs_rise   = ~cs_prev_q & cs_s;
   assign shift_in  = {mosi_s, shift_q[DATA_WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         shift_q     <= '0;
         tx_buf_q    <= '0;
         rx_data_q   <= '0;
         cnt_q       <= '0;
         tx_ready_q  <= 1'b1;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         underrun_q  <= 1'b0;
         first_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
         shift_q     <= shift_d;
         tx_buf_q    <= tx_buf_d;
         rx_data_q   <= rx_data_d;
         cnt_q       <= cnt_d;
         tx_ready_q  <= tx_ready_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         underrun_q  <= underrun_d;
         first_q     <= first_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      tx_buf_d    = tx_buf_q;
      rx_data_d   = rx_data_q;
      cnt_d       = cnt_q;
      tx_ready_d  = tx_ready_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      underrun_d  = 1'b0;
      first_d     = first_q;
      reload      = 1'b0;
      case (state_q)
         IDLE: begin
            // an SCLK fall coinciding with the CS fall is deliberately dropped
            if (cs_fall) begin
               state_d = ACTIVE;
               cnt_d   = '0;
               first_d = 1'b1;
               reload  = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d     = IDLE;
               frame_err_d = (cnt_q != '0);
               cnt_d       = '0;
               first_d     = 1'b0;
            end else if (sclk_fall) begin
               first_d = 1'b0;
               if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                  rx_data_d  = shift_in;
                  rx_valid_d = 1'b1;
                  cnt_d      = '0;
                  reload     = 1'b1;
               end else begin
                  shift_d = shift_in;
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // reload takes the buffer as it stood before any same-cycle txLoad
      if (reload) begin
         shift_d    = tx_buf_q;
         underrun_d = tx_ready_q;
         tx_ready_d = 1'b1;
      end
      if (txLoad) begin
         tx_buf_d   = slaveDataToSend;
         tx_ready_d = 1'b0;
      end
   end

   assign MISO              = (state_q == ACTIVE) ? shift_q[0] : 1'b0;
   assign MISO_oe           = (state_q == ACTIVE);
   assign busy              = (state_q == ACTIVE) && ((cnt_q != '0) || first_q);
   assign txReady           = tx_ready_q;
   assign slaveDataReceived = rx_data_q;
   assign rxValid           = rx_valid_q;
   assign frameError        = frame_err_q;
   assign txUnderrun        = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed plus randomized bench for spi_slave; a word-level model tracks the
// transmit buffer, the words the master should see and the pulse counts.
module tb_spi_slave;
   localparam int W    = 8;
   localparam int HALF = 8;

   logic         clk = 1'b0;
   logic         reset, SCLK, CS, MOSI, txLoad;
   logic         MISO, MISO_oe, txReady, rxValid, busy, frameError, txUnderrun;
   logic [W-1:0] slaveDataToSend, slaveDataReceived;

   always #5 clk = ~clk;

   spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk               (clk),
      .reset             (reset),
      .SCLK              (SCLK),
      .CS                (CS),
      .MOSI              (MOSI),
      .MISO              (MISO),
      .MISO_oe           (MISO_oe),
      .slaveDataToSend   (slaveDataToSend),
      .txLoad            (txLoad),
      .txReady           (txReady),
      .slaveDataReceived (slaveDataReceived),
      .rxValid           (rxValid),
      .busy              (busy),
      .frameError        (frameError),
      .txUnderrun        (txUnderrun)
   );

   int vectors = 0;
   int miscompares = 0;

   int           rx_seen = 0, ferr_seen = 0, undr_seen = 0;
   logic [W-1:0] rx_last = '0;

   always @(negedge clk) begin
      if (rxValid) begin
         rx_seen++;
         rx_last = slaveDataReceived;
      end
      if (frameError) ferr_seen++;
      if (txUnderrun) undr_seen++;
   end

   // word-level model: latest loaded word, whether one is pending, word on the wire
   logic [W-1:0] m_buf = '0;
   logic [W-1:0] m_sent = '0;
   bit           m_loaded = 1'b0;
   int           exp_rx = 0, exp_ferr = 0, exp_undr = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic m_reload();
      m_sent = m_buf;
      if (!m_loaded) exp_undr++;
      m_loaded = 1'b0;
   endtask

   task automatic load(input logic [W-1:0] w);
      slaveDataToSend = w;
      txLoad = 1'b1;
      tick(1);
      txLoad = 1'b0;
      m_buf = w;
      m_loaded = 1'b1;
      tick(1);
   endtask

   task automatic spi_bits(input logic [W-1:0] mosi_w, input int nbits, output logic [W-1:0] miso_w);
      miso_w = '0;
      for (int i = 0; i < nbits; i++) begin
         MOSI = mosi_w[i];
         tick(HALF);
         SCLK = 1'b1;
         tick(HALF);
         miso_w[i] = MISO;
         SCLK = 1'b0;
         tick(HALF);
      end
   endtask

   task automatic cs_start();
      CS = 1'b0;
      tick(6);
      m_reload();
      chk("oe_active", MISO_oe, 1'b1);
      chk("busy_at_start", busy, 1'b1);
      chk("underruns_start", undr_seen, exp_undr);
   endtask

   task automatic cs_end(input bit partial);
      CS = 1'b1;
      tick(6);
      if (partial) exp_ferr++;
      chk("frame_errors", ferr_seen, exp_ferr);
      chk("oe_idle", MISO_oe, 1'b0);
   endtask

   task automatic full_frame(input logic [W-1:0] mosi_w);
      logic [W-1:0] got;
      spi_bits(mosi_w, W, got);
      chk("miso_word", got, m_sent);
      exp_rx++;
      m_reload();
      chk("rx_count", rx_seen, exp_rx);
      chk("rx_data", rx_last, mosi_w);
      chk("rx_out", slaveDataReceived, mosi_w);
      chk("underruns", undr_seen, exp_undr);
      chk("tx_ready", txReady, !m_loaded);
      chk("busy_between", busy, 1'b0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_miso", MISO, 1'b0);
      chk("rst_oe", MISO_oe, 1'b0);
      chk("rst_txready", txReady, 1'b1);
      chk("rst_rxvalid", rxValid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ferr", frameError, 1'b0);
      chk("rst_undr", txUnderrun, 1'b0);
      chk("rst_rxdata", slaveDataReceived, '0);
   endtask

   initial begin
      logic [W-1:0] partial_w;
      logic [W-1:0] rx_before;
      reset = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
      txLoad = 1'b0; slaveDataToSend = '0;
      tick(4);
      check_reset_outputs();
      reset = 1'b0;
      tick(4);

      // single frame: send 0x3C, receive 0xA5
      load(8'h3C);
      chk("txready_after_load", txReady, 1'b0);
      cs_start();
      chk("txready_after_start", txReady, 1'b1);
      full_frame(8'hA5);
      cs_end(1'b0);

      // two frames under one CS, second tx word loaded mid-first-frame
      load(8'h77);
      cs_start();
      load(8'h55);
      full_frame(8'h11);
      full_frame(8'h22);
      cs_end(1'b0);

      // aborted frame, then a good one that resends the word
      load(8'h12);
      cs_start();
      rx_before = slaveDataReceived;
      spi_bits(8'h1F, 5, partial_w);
      chk("busy_mid_frame", busy, 1'b1);
      cs_end(1'b1);
      chk("rx_count_abort", rx_seen, exp_rx);
      chk("rx_unchanged", slaveDataReceived, rx_before);
      cs_start();
      full_frame(8'h6B);
      cs_end(1'b0);

      // underrun: no new load, 0x81 goes out again
      load(8'h81);
      cs_start();
      full_frame(8'h3D);
      cs_end(1'b0);
      cs_start();
      full_frame(8'hC4);
      cs_end(1'b0);

      // reset mid-frame
      load(8'h99);
      cs_start();
      spi_bits(8'h0F, 4, partial_w);
      reset = 1'b1;
      tick(2);
      CS = 1'b1;
      tick(4);
      check_reset_outputs();
      chk("ferr_count_reset", ferr_seen, exp_ferr);
      reset = 1'b0;
      m_buf = '0;
      m_loaded = 1'b0;
      tick(6);
      chk("idle_after_reset", MISO_oe, 1'b0);
      cs_start();
      full_frame(8'hF0);
      cs_end(1'b0);

      // randomized traffic
      for (int it = 0; it < 12; it++) begin
         int nfr;
         if ($urandom_range(1, 0) == 1) load(W'($urandom));
         cs_start();
         nfr = $urandom_range(3, 1);
         for (int f = 0; f < nfr; f++) begin
            if ($urandom_range(2, 0) == 0) load(W'($urandom));
            full_frame(W'($urandom));
         end
         cs_end(1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
- REQ-001 Parameter DATA_WIDTH, default 8: frame length in bits.
- REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: flip-flop stages on SCLK, CS and MOSI.
- REQ-003 Clocking: one clock; reset is synchronous and active-high.
- REQ-004 clk  input  1  system clock, at least 8x SCLK frequency.
- REQ-005 reset  input  1  synchronous active-high reset.
- REQ-006 SCLK  input  1  serial clock from the master; asynchronous to clk; idles low.
- REQ-007 CS  input  1  active-low select for this slave (one bit of the master's CS bus).
- REQ-008 MOSI  input  1  serial data from the master, LSB first.
- REQ-009 MISO  output  1  serial data to the master, LSB first.
- REQ-010 MISO_oe  output  1  high while this slave drives MISO.
- REQ-011 slaveDataToSend  input  DATA_WIDTH  transmit word.
- REQ-012 txLoad  input  1  writes slaveDataToSend into the transmit buffer.
- REQ-013 txReady  output  1  transmit buffer is empty and can be written.
- REQ-014 slaveDataReceived  output  DATA_WIDTH  last complete received word.
- REQ-015 rxValid  output  1  one-cycle pulse: slaveDataReceived was updated.
- REQ-016 busy  output  1  a frame is in progress.
- REQ-017 frameError  output  1  one-cycle pulse: CS deasserted mid-frame.
- REQ-018 txUnderrun  output  1  one-cycle pulse: a frame started with txReady high.

Function
- REQ-019 SCLK, CS and MOSI pass through SYNC_STAGES synchronizer flops. All edge detection uses the synchronized values only: a fall is the previous value 1 and the current value 0.
- REQ-020 FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE on a synchronized CS fall.
  - ACTIVE -> IDLE on a synchronized CS rise.
- REQ-021 On entry to ACTIVE:
  - shift register <= transmit buffer, bit counter <= 0, txReady <= 1.
  - If txReady was already 1, the last loaded word is sent again and txUnderrun pulses.
- REQ-022 MISO = shift register bit 0 whenever in ACTIVE, so the first bit is valid before the first SCLK edge. MISO_oe = 1 in ACTIVE and 0 in IDLE. MISO = 0 in IDLE.
- REQ-023 Each synchronized SCLK fall in ACTIVE:
  - shift register <= {synchronized MOSI, shift register[DATA_WIDTH-1:1]};
  - bit counter increments.
- REQ-024 Synchronized SCLK rises cause no state change. MOSI is sampled on the fall only.
- REQ-025 Frame completion: on the fall that makes the counter reach DATA_WIDTH:
  - slaveDataReceived <= the new shift value;
  - rxValid pulses on the next cycle;
  - counter wraps to 0;
  - shift register reloads from the transmit buffer (same rules as REQ-021, including txUnderrun), so back-to-back frames under one CS assertion work.
- REQ-026 txLoad is accepted in any state. It writes the buffer and clears txReady. If txLoad coincides with a frame-start reload, the reload takes the old buffer and the new word stays queued with txReady = 0.
- REQ-027 CS rise with counter != 0: frameError pulses, the partial word is discarded and slaveDataReceived is unchanged. CS rise with counter == 0: no error.
- REQ-028 busy = 1 in ACTIVE when counter != 0, or when the first edge is pending after entry.
- REQ-029 A CS fall and an SCLK fall in the same cycle: CS is handled first and the SCLK fall is ignored.

Reset
- REQ-030 On reset = 1 at a clk rising edge, regardless of state (including mid-frame):
  - FSM -> IDLE;
  - shift register, transmit buffer, slaveDataReceived and counter = 0;
  - MISO = 0, MISO_oe = 0, txReady = 1;
  - rxValid, busy, frameError, txUnderrun = 0;
  - synchronizers preset so that CS = 1 and SCLK = 0.
- REQ-031 Frame activity continuing after reset deasserts is ignored until the next synchronized CS fall.

Verification
- REQ-032 Load 0x3C, drive CS low, clock 8 SCLK cycles with MOSI = 0xA5 LSB first. Required: MISO bits LSB first = 0x3C, slaveDataReceived = 0xA5, one rxValid pulse, txReady = 1.
- REQ-033 Under one CS assertion, 16 SCLK cycles with MOSI 0x11 then 0x22, and 0x55 loaded after the first frame starts. Required: two rxValid pulses (0x11, 0x22); MISO sends the first loaded word, then 0x55.
- REQ-034 CS rises after 5 SCLK cycles. Required: frameError pulses once, no rxValid, slaveDataReceived unchanged; the next full frame is received correctly.
- REQ-035 A frame starts without txLoad after a prior 0x81 send. Required: txUnderrun pulses and MISO resends 0x81.
- REQ-036 Assert reset after 4 SCLK cycles. Required: all outputs at the REQ-030 values; the next CS-low frame of 0xF0 yields slaveDataReceived = 0xF0.
